apb_req_bridge: RTL and testbench

//  Converts the core's valid/ready load/store request channel into APB4 master transfers.

---
 rtl/apb_pkg.sv | 8 +
 rtl/apb_if.sv | 31 +++
 rtl/apb_req_bridge.sv | 149 ++++++++++++++
 tb/tb_apb_req_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states and protection field width.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mstate_t;

  localparam int APB_PROT_W = 3;

endpackage

// File: rtl/apb_if.sv
// APB4 bus bundle. The master drives address phase and write data; the slave returns
// pready/prdata/pslverr.
interface APB
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   paddr;
  logic [APB_PROT_W-1:0]   pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport Master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport Slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_req_bridge.sv
// Bridges the core's valid/ready load/store request channel onto an APB4 master port.
// One transfer is in flight at a time; a pready timeout guarantees every request is
// answered on the response channel even if the addressed slave never responds.
module apb_req_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [APB_PROT_W-1:0]   req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  APB.Master                      apb_m
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  // Wide enough to hold TIMEOUT_CYCLES itself; a disabled timeout still gets one bit.
  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    TIMER_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  apb_mstate_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   paddr_reg;
  logic [APB_PROT_W-1:0]   pprot_reg;
  logic                    pwrite_reg;
  logic [DATA_WIDTH-1:0]   pwdata_reg;
  logic [STRB_WIDTH-1:0]   pstrb_reg;
  logic [TIMER_WIDTH-1:0]  timer_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic                    rsp_err_reg;

  logic psel_next;
  logic penable_next;
  logic access_done;
  logic timeout_hit;
  logic req_misaligned;

  // Only word-aligned accesses are forwarded to the bus.
  assign req_misaligned = (req_addr[1:0] != 2'b00);

  // Next-state decode plus the psel/penable phase signals for the current state.
  always_comb begin
    state_next   = state_reg;
    psel_next    = 1'b0;
    penable_next = 1'b0;
    access_done  = 1'b0;
    timeout_hit  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = req_misaligned ? RESP : SETUP;
        end
      end
      SETUP: begin
        psel_next  = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel_next    = 1'b1;
        penable_next = 1'b1;
        // pready has priority over a timeout expiring in the same cycle.
        if (apb_m.pready) begin
          access_done = 1'b1;
          state_next  = RESP;
        end else if (TIMEOUT_EN && (timer_reg == TIMER_LAST)) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, latched request fields, timeout timer and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      paddr_reg     <= '0;
      pprot_reg     <= '0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
      pstrb_reg     <= '0;
      timer_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            paddr_reg  <= req_addr;
            pprot_reg  <= req_prot;
            pwrite_reg <= req_write;
            pwdata_reg <= req_wdata;
            pstrb_reg  <= req_write ? req_strb : '0;
            timer_reg  <= '0;
            if (req_misaligned) begin
              rsp_rdata_reg <= '0;
              rsp_err_reg   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          timer_reg <= timer_reg + TIMER_WIDTH'(1);
          if (access_done) begin
            rsp_err_reg   <= apb_m.pslverr;
            // Writes and slave errors return zero data.
            rsp_rdata_reg <= (pwrite_reg || apb_m.pslverr) ? '0 : apb_m.prdata;
          end else if (timeout_hit) begin
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  assign apb_m.psel    = psel_next;
  assign apb_m.penable = penable_next;
  assign apb_m.paddr   = paddr_reg;
  assign apb_m.pprot   = pprot_reg;
  assign apb_m.pwrite  = pwrite_reg;
  assign apb_m.pwdata  = pwdata_reg;
  assign apb_m.pstrb   = pstrb_reg;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge with an 8-cycle pready timeout.
module tb_apb_req_bridge;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  APB #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_bus ();

  apb_req_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .apb_m(apb_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE and let one edge accept it; returns in the cycle after.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot);
    req_addr  = addr;
    req_write = wr;
    req_wdata = wdata;
    req_strb  = strb;
    req_prot  = prot;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    apb_bus.pready  = 1'b0;
    apb_bus.prdata  = '0;
    apb_bus.pslverr = 1'b0;
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got rdata=%h err=%b want 0/0", rsp_rdata, rsp_err); end
    checks++; if (apb_bus.psel !== 1'b0 || apb_bus.penable !== 1'b0) begin errors++; $display("FAIL reset_psel: got psel=%b penable=%b want 0/0", apb_bus.psel, apb_bus.penable); end
    checks++; if (apb_bus.paddr !== 32'h0 || apb_bus.pwdata !== 32'h0 || apb_bus.pstrb !== 4'h0 || apb_bus.pprot !== 3'h0 || apb_bus.pwrite !== 1'b0) begin
      errors++; $display("FAIL reset_apb_regs: got paddr=%h pwdata=%h pstrb=%h pprot=%h pwrite=%b want all 0", apb_bus.paddr, apb_bus.pwdata, apb_bus.pstrb, apb_bus.pprot, apb_bus.pwrite);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    $display("reset: req_ready=%b rsp_valid=%b psel=%b", req_ready, rsp_valid, apb_bus.psel);
  endtask

  task automatic test_read_zero_wait();
    issue(32'h0000_1000, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010);
    // cycle 1: SETUP
    checks++; if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b0) begin errors++; $display("FAIL rd_setup_phase: got psel=%b penable=%b want 1/0", apb_bus.psel, apb_bus.penable); end
    checks++; if (apb_bus.paddr !== 32'h0000_1000 || apb_bus.pwrite !== 1'b0 || apb_bus.pprot !== 3'b010) begin errors++; $display("FAIL rd_setup_addr: got paddr=%h pwrite=%b pprot=%h want 1000/0/2", apb_bus.paddr, apb_bus.pwrite, apb_bus.pprot); end
    checks++; if (apb_bus.pstrb !== 4'h0) begin errors++; $display("FAIL rd_pstrb_zero: got %h want 0", apb_bus.pstrb); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rd_req_ready_busy: got %b want 0", req_ready); end
    tick();
    // cycle 2: ACCESS, slave answers immediately
    apb_bus.pready = 1'b1;
    apb_bus.prdata = 32'hDEAD_BEEF;
    checks++; if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_access_phase: got psel=%b penable=%b rsp_valid=%b want 1/1/0", apb_bus.psel, apb_bus.penable, rsp_valid); end
    tick();
    apb_bus.pready = 1'b0;
    // cycle 3: response
    checks++; if (rsp_valid !== 1'b1 || apb_bus.psel !== 1'b0) begin errors++; $display("FAIL rd_rsp_cycle3: got rsp_valid=%b psel=%b want 1/0", rsp_valid, apb_bus.psel); end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_data: got rdata=%h err=%b want deadbeef/0", rsp_rdata, rsp_err); end
    $display("read 0x1000: rdata=%h err=%b", rsp_rdata, rsp_err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rd_back_idle: got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_write_waits();
    issue(32'h0000_2004, 1'b1, 32'hA5A5_A5A5, 4'h3, 3'b000);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b1 || apb_bus.paddr !== 32'h0000_2004 ||
          apb_bus.pwdata !== 32'hA5A5_A5A5 || apb_bus.pstrb !== 4'h3 || apb_bus.pwrite !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL wr_wait_stable[%0d]: got psel=%b pen=%b paddr=%h pwdata=%h pstrb=%h pwrite=%b rsp_valid=%b want 1/1/2004/a5a5a5a5/3/1/0",
                 i, apb_bus.psel, apb_bus.penable, apb_bus.paddr, apb_bus.pwdata, apb_bus.pstrb, apb_bus.pwrite, rsp_valid);
      end
      tick();
    end
    apb_bus.pready  = 1'b1;
    apb_bus.prdata  = 32'h1234_5678;
    apb_bus.pslverr = 1'b0;
    checks++; if (apb_bus.paddr !== 32'h0000_2004 || apb_bus.pwdata !== 32'hA5A5_A5A5 || apb_bus.penable !== 1'b1) begin errors++; $display("FAIL wr_final_access: got paddr=%h pwdata=%h penable=%b want 2004/a5a5a5a5/1", apb_bus.paddr, apb_bus.pwdata, apb_bus.penable); end
    tick();
    apb_bus.pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got valid=%b rdata=%h err=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
    $display("write 0x2004: rdata=%h err=%b", rsp_rdata, rsp_err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_slverr();
    issue(32'h0000_1010, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    apb_bus.pready  = 1'b1;
    apb_bus.pslverr = 1'b1;
    apb_bus.prdata  = 32'h1111_1111;
    tick();
    apb_bus.pready  = 1'b0;
    apb_bus.pslverr = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL slverr_rsp: got valid=%b err=%b rdata=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    $display("read 0x1010 slverr: rdata=%h err=%b", rsp_rdata, rsp_err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int access_cycles;
    access_cycles = 0;
    apb_bus.prdata = 32'h5555_AAAA;
    issue(32'h0000_4000, 1'b0, 32'h0, 4'h0, 3'b001);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (!(apb_bus.psel === 1'b1 && apb_bus.penable === 1'b1)) break;
      access_cycles++;
      tick();
    end
    checks++; if (access_cycles !== 8) begin errors++; $display("FAIL timeout_access_cycles: got %0d want 8", access_cycles); end
    checks++; if (apb_bus.psel !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL timeout_release: got psel=%b rsp_valid=%b want 0/1", apb_bus.psel, rsp_valid); end
    checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rsp: got err=%b rdata=%h want 1/0", rsp_err, rsp_rdata); end
    $display("read 0x4000 timeout: access_cycles=%0d err=%b rdata=%h", access_cycles, rsp_err, rsp_rdata);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout_race();
    issue(32'h0000_4100, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    repeat (7) tick();
    // eighth ACCESS cycle: timer at its last value
    checks++; if (apb_bus.penable !== 1'b1) begin errors++; $display("FAIL race_still_access: got penable=%b want 1", apb_bus.penable); end
    apb_bus.pready  = 1'b1;
    apb_bus.pslverr = 1'b0;
    apb_bus.prdata  = 32'hCAFE_F00D;
    tick();
    apb_bus.pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL race_rsp: got valid=%b err=%b rdata=%h want 1/0/cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    $display("read 0x4100 race: rdata=%h err=%b", rsp_rdata, rsp_err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    issue(32'h0000_3002, 1'b0, 32'h0, 4'h0, 3'b000);
    checks++; if (apb_bus.psel !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL misal_no_xfer: got psel=%b rsp_valid=%b want 0/1", apb_bus.psel, rsp_valid); end
    checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin errors++; $display("FAIL misal_rsp: got err=%b rdata=%h req_ready=%b want 1/0/0", rsp_err, rsp_rdata, req_ready); end
    $display("read 0x3002 misaligned: err=%b rdata=%h", rsp_err, rsp_rdata);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (apb_bus.psel !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL misal_idle: got psel=%b req_ready=%b want 0/1", apb_bus.psel, req_ready); end
  endtask

  task automatic test_backpressure_reset();
    issue(32'h0000_5000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    apb_bus.pready = 1'b1;
    apb_bus.prdata = 32'h0BAD_F00D;
    tick();
    apb_bus.pready = 1'b0;
    apb_bus.prdata = 32'h0;
    // a competing request is held while the response stalls
    req_addr  = 32'h0000_6000;
    req_write = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0 || req_ready !== 1'b0 || apb_bus.psel !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b req_ready=%b psel=%b want 1/0badf00d/0/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, apb_bus.psel);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // IDLE for one cycle before the pending request is taken
    checks++; if (req_ready !== 1'b1 || apb_bus.psel !== 1'b0) begin errors++; $display("FAIL bp_gap_idle: got req_ready=%b psel=%b want 1/0", req_ready, apb_bus.psel); end
    tick();
    req_valid = 1'b0;
    checks++; if (apb_bus.psel !== 1'b1 || apb_bus.paddr !== 32'h0000_6000) begin errors++; $display("FAIL bp_next_setup: got psel=%b paddr=%h want 1/6000", apb_bus.psel, apb_bus.paddr); end
    tick();
    checks++; if (apb_bus.penable !== 1'b1) begin errors++; $display("FAIL bp_next_access: got penable=%b want 1", apb_bus.penable); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (apb_bus.psel !== 1'b0 || apb_bus.penable !== 1'b0) begin errors++; $display("FAIL rst_async_psel: got psel=%b penable=%b want 0/0", apb_bus.psel, apb_bus.penable); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_async_idle: got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || apb_bus.psel !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_idle: got rsp_valid=%b psel=%b req_ready=%b want 0/0/1", rsp_valid, apb_bus.psel, req_ready); end
    $display("backpressure+reset: rsp_valid=%b psel=%b req_ready=%b", rsp_valid, apb_bus.psel, req_ready);
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_slverr();
    test_timeout();
    test_timeout_race();
    test_misaligned();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
